// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the single-issue MIPS core.
// Define MC_CTRL_BLTZAL_EN to decode bltzal (op 0x01, rt 0x10); otherwise op 0x01 is illegal.
module mc_ctrl #(
  parameter logic [2:0]  RESET_STATE = 3'd0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic [4:0]       rt,
  output logic             ir_we,
  output logic             pc_we,
  output logic             npc_sel,
  output logic             j_ctl,
  output logic             jr_ctl,
  output logic             bltzal,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             ext_op,
  output logic             mem_we,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExe    = 3'd2,
    StMemRd  = 3'd3,
    StMemWr  = 3'd4,
    StWb     = 3'd5,
    StBr     = 3'd6,
    StJmp    = 3'd7
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnJr    = 6'h08;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal, is_bltzal;
  logic is_alu, is_branch, is_jump, is_legal;
  logic alu_src_c, ext_op_c;
  logic [1:0] alu_op_c;
  logic ir_we_raw, pc_we_raw, reg_we_raw, mem_we_raw, illegal_raw, count_en;

  assign is_rtype = (op == OpRtype);
  assign is_addu  = is_rtype && (funct == FnAddu);
  assign is_subu  = is_rtype && (funct == FnSubu);
  assign is_jr    = is_rtype && (funct == FnJr);
  assign is_ori   = (op == OpOri);
  assign is_lui   = (op == OpLui);
  assign is_lw    = (op == OpLw);
  assign is_sw    = (op == OpSw);
  assign is_beq   = (op == OpBeq);
  assign is_j     = (op == OpJ);
  assign is_jal   = (op == OpJal);

`ifdef MC_CTRL_BLTZAL_EN
  localparam logic [5:0] OpRegimm = 6'h01;
  localparam logic [4:0] RtBltzal = 5'h10;
  assign is_bltzal = (op == OpRegimm) && (rt == RtBltzal);
`else
  logic unused_rt;
  assign unused_rt = ^rt;
  assign is_bltzal = 1'b0;
`endif

  assign is_alu    = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw;
  assign is_branch = is_beq | is_bltzal;
  assign is_jump   = is_j | is_jal | is_jr;
  assign is_legal  = is_alu | is_branch | is_jump;

  // ALU controls stay valid from EXE through the end of the datapath use.
  assign alu_src_c = is_ori | is_lui | is_lw | is_sw;
  assign ext_op_c  = is_lw | is_sw;
  assign alu_op_c  = is_subu ? 2'd1 : is_ori ? 2'd2 : is_lui ? 2'd3 : 2'd0;

  always_comb begin
    state_d     = state_q;
    ir_we_raw   = 1'b0;
    pc_we_raw   = 1'b0;
    reg_we_raw  = 1'b0;
    mem_we_raw  = 1'b0;
    illegal_raw = 1'b0;
    npc_sel     = 1'b0;
    j_ctl       = 1'b0;
    jr_ctl      = 1'b0;
    bltzal      = 1'b0;
    reg_dst     = 2'd0;
    wd_sel      = 2'd0;
    alu_src     = 1'b0;
    alu_op      = 2'd0;
    ext_op      = 1'b0;
    unique case (state_q)
      StFetch: begin
        ir_we_raw = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        if (!is_legal) begin
          illegal_raw = 1'b1;
          pc_we_raw   = 1'b1;
          state_d     = StFetch;
        end else if (is_alu) begin
          state_d = StExe;
        end else if (is_branch) begin
          state_d = StBr;
        end else begin
          state_d = StJmp;
        end
      end
      StExe, StMemRd, StMemWr, StWb: begin
        alu_src = alu_src_c;
        alu_op  = alu_op_c;
        ext_op  = ext_op_c;
        if (state_q == StExe) begin
          state_d = is_lw ? StMemRd : (is_sw ? StMemWr : StWb);
        end else if (state_q == StMemRd) begin
          state_d = StWb;
        end else if (state_q == StMemWr) begin
          mem_we_raw = 1'b1;
          pc_we_raw  = 1'b1;
          state_d    = StFetch;
        end else begin
          reg_we_raw = 1'b1;
          pc_we_raw  = 1'b1;
          reg_dst    = is_rtype ? 2'd1 : 2'd0;
          wd_sel     = is_lw ? 2'd1 : 2'd0;
          state_d    = StFetch;
        end
      end
      StBr: begin
        pc_we_raw = 1'b1;
        npc_sel   = 1'b1;
        ext_op    = 1'b1;
        alu_op    = 2'd1;
        if (is_bltzal) begin
          bltzal     = 1'b1;
          reg_we_raw = 1'b1;
          reg_dst    = 2'd2;
          wd_sel     = 2'd2;
        end
        state_d = StFetch;
      end
      StJmp: begin
        pc_we_raw = 1'b1;
        npc_sel   = 1'b1;
        j_ctl     = is_j | is_jal;
        jr_ctl    = is_jr;
        if (is_jal) begin
          reg_we_raw = 1'b1;
          reg_dst    = 2'd2;
          wd_sel     = 2'd2;
        end
        state_d = StFetch;
      end
    endcase
    if (hold) begin
      state_d = state_q;
    end
  end

  assign ir_we   = ir_we_raw & ~hold;
  assign pc_we   = pc_we_raw & ~hold;
  assign reg_we  = reg_we_raw & ~hold;
  assign mem_we  = mem_we_raw & ~hold;
  assign illegal = illegal_raw & ~hold;

  // A skipped illegal instruction updates the PC but is not a retirement.
  assign count_en  = pc_we_raw & ~illegal_raw & ~hold;
  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, count_en};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= state_e'(RESET_STATE);
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: expected per-cycle outputs are queued as stimulus is driven.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset, hold;
  logic [5:0]  op, funct;
  logic [4:0]  rt;
  logic        ir_we, pc_we, npc_sel, j_ctl, jr_ctl, bltzal, reg_we;
  logic [1:0]  reg_dst, wd_sel, alu_op;
  logic        alu_src, ext_op, mem_we, illegal;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        w_ir_we, w_pc_we, w_npc_sel, w_j_ctl, w_jr_ctl, w_bltzal, w_reg_we;
  logic [1:0]  w_reg_dst, w_wd_sel, w_alu_op;
  logic        w_alu_src, w_ext_op, w_mem_we, w_illegal;
  logic [2:0]  w_state;
  logic [1:0]  w_retired;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .hold(hold), .op(op), .funct(funct), .rt(rt),
    .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .j_ctl(j_ctl), .jr_ctl(jr_ctl),
    .bltzal(bltzal), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .mem_we(mem_we),
    .illegal(illegal), .state(state), .retired(retired)
  );

  // Narrow counter instance so modulo wrap is reached in a short run.
  mc_ctrl #(.CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .hold(hold), .op(op), .funct(funct), .rt(rt),
    .ir_we(w_ir_we), .pc_we(w_pc_we), .npc_sel(w_npc_sel), .j_ctl(w_j_ctl),
    .jr_ctl(w_jr_ctl), .bltzal(w_bltzal), .reg_we(w_reg_we), .reg_dst(w_reg_dst),
    .wd_sel(w_wd_sel), .alu_src(w_alu_src), .alu_op(w_alu_op), .ext_op(w_ext_op),
    .mem_we(w_mem_we), .illegal(w_illegal), .state(w_state), .retired(w_retired)
  );

  always #5 clk = ~clk;

`ifdef MC_CTRL_BLTZAL_EN
  localparam bit BlEn = 1'b1;
`else
  localparam bit BlEn = 1'b0;
`endif

  localparam int KAddu = 0, KSubu = 1, KJr = 2, KOri = 3, KLui = 4, KLw = 5, KSw = 6;
  localparam int KBeq = 7, KJ = 8, KJal = 9, KBltzal = 10, KBad = 11, KBadFn = 12;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we, pc_we, npc_sel, j_ctl, jr_ctl, bl, reg_we;
    logic [1:0] reg_dst, wd_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       ext_op, mem_we, ill;
  } out_t;

  typedef struct {
    out_t        o;
    logic [31:0] ret;
    string       tag;
  } rec_t;

  out_t        obs_o;
  rec_t        sb[$];
  rec_t        cur;
  out_t        got_o;
  logic [31:0] exp_ret;
  int          total = 0;
  int          bad = 0;

  assign obs_o = {state, ir_we, pc_we, npc_sel, j_ctl, jr_ctl, bltzal, reg_we, reg_dst, wd_sel,
                  alu_src, alu_op, ext_op, mem_we, illegal};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic out_t model(input int k, input logic [2:0] st, input bit held);
    out_t e;
    bit   legal, is_r;
    legal = !(k == KBad || k == KBadFn || (k == KBltzal && !BlEn));
    is_r  = (k == KAddu || k == KSubu);
    e     = '0;
    e.st  = st;
    case (st)
      3'd0: e.ir_we = 1'b1;
      3'd1: if (!legal) begin
        e.ill   = 1'b1;
        e.pc_we = 1'b1;
      end
      3'd2, 3'd3, 3'd5: begin
        e.alu_src = (k == KOri || k == KLui || k == KLw || k == KSw);
        e.ext_op  = (k == KLw || k == KSw);
        e.alu_op  = (k == KSubu) ? 2'd1 : (k == KOri) ? 2'd2 : (k == KLui) ? 2'd3 : 2'd0;
        if (st == 3'd5) begin
          e.reg_we  = 1'b1;
          e.pc_we   = 1'b1;
          e.reg_dst = is_r ? 2'd1 : 2'd0;
          e.wd_sel  = (k == KLw) ? 2'd1 : 2'd0;
        end
      end
      3'd4: begin
        e.mem_we = 1'b1;
        e.pc_we  = 1'b1;
      end
      3'd6: begin
        e.pc_we   = 1'b1;
        e.npc_sel = 1'b1;
        e.ext_op  = 1'b1;
        e.alu_op  = 2'd1;
        if (k == KBltzal) begin
          e.bl      = 1'b1;
          e.reg_we  = 1'b1;
          e.reg_dst = 2'd2;
          e.wd_sel  = 2'd2;
        end
      end
      default: begin
        e.pc_we   = 1'b1;
        e.npc_sel = 1'b1;
        e.j_ctl   = (k == KJ || k == KJal);
        e.jr_ctl  = (k == KJr);
        if (k == KJal) begin
          e.reg_we  = 1'b1;
          e.reg_dst = 2'd2;
          e.wd_sel  = 2'd2;
        end
      end
    endcase
    if (held) begin
      e.ir_we  = 1'b0;
      e.pc_we  = 1'b0;
      e.reg_we = 1'b0;
      e.mem_we = 1'b0;
      e.ill    = 1'b0;
    end
    return e;
  endfunction

  task automatic push(input string nm, input int k, input logic [2:0] st, input bit held);
    rec_t r;
    r.o   = model(k, st, held);
    r.ret = exp_ret;
    r.tag = $sformatf("%s_s%0d%s", nm, st, held ? "_hold" : "");
    sb.push_back(r);
    if (!held && r.o.pc_we && st != 3'd1) exp_ret++;
  endtask

  // Called just after a rising edge with the DUT in FETCH.
  task automatic run(input int k, input string nm, input int hold_st, input int hold_n,
                     input int abort_st);
    int         path[$];
    logic [2:0] st;
    out_t       e;
    op = 6'h00; funct = 6'h00; rt = 5'h00;
    case (k)
      KAddu:   funct = 6'h21;
      KSubu:   funct = 6'h23;
      KJr:     funct = 6'h08;
      KOri:    op = 6'h0D;
      KLui:    op = 6'h0F;
      KLw:     op = 6'h23;
      KSw:     op = 6'h2B;
      KBeq:    op = 6'h04;
      KJ:      op = 6'h02;
      KJal:    op = 6'h03;
      KBltzal: begin op = 6'h01; rt = 5'h10; end
      KBad:    op = 6'h3F;
      default: funct = 6'h20;
    endcase
    case (k)
      KLw:               path = '{0, 1, 2, 3, 5};
      KSw:               path = '{0, 1, 2, 4};
      KBeq:              path = '{0, 1, 6};
      KBltzal:           if (BlEn) path = '{0, 1, 6}; else path = '{0, 1};
      KJ, KJal, KJr:     path = '{0, 1, 7};
      KBad, KBadFn:      path = '{0, 1};
      default:           path = '{0, 1, 2, 5};
    endcase
    foreach (path[i]) begin
      st = 3'(path[i]);
      if (path[i] == hold_st) begin
        for (int h = 0; h < hold_n; h++) begin
          hold = 1'b1;
          push(nm, k, st, 1'b1);
          @(posedge clk); #1;
        end
      end
      hold = 1'b0;
      push(nm, k, st, 1'b0);
      if (path[i] == abort_st) begin
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        e       = '0;
        e.ir_we = 1'b1;
        check_eq({nm, "_abort_out"}, 64'(obs_o), 64'(e));
        check_eq({nm, "_abort_ret"}, 64'(retired), 64'd0);
        check_eq({nm, "_abort_ret_w"}, 64'(w_retired), 64'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        exp_ret = '0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur   = sb.pop_front();
      got_o = obs_o;
      // ALU selects during the store write are not pinned down; compare enables only.
      if (cur.o.st == 3'd4) begin
        got_o.alu_src = 1'b0;
        got_o.alu_op  = 2'd0;
        got_o.ext_op  = 1'b0;
      end
      check_eq(cur.tag, 64'(got_o), 64'(cur.o));
      check_eq({cur.tag, "_ret"}, 64'(retired), 64'(cur.ret));
      check_eq({cur.tag, "_ret_w"}, 64'(w_retired), 64'(cur.ret[1:0]));
    end
  end

  initial begin
    out_t e;
    reset = 1'b1; hold = 1'b0; op = 6'h00; funct = 6'h00; rt = 5'h00;
    exp_ret = '0;
    repeat (2) @(posedge clk);
    #1;
    e       = '0;
    e.ir_we = 1'b1;
    check_eq("reset_out", 64'(obs_o), 64'(e));
    check_eq("reset_ret", 64'(retired), 64'd0);
    reset = 1'b0;

    run(KOri,    "ori",    -1, 0, -1);
    run(KAddu,   "addu",   -1, 0, -1);
    run(KSubu,   "subu",   -1, 0, -1);
    run(KLui,    "lui",    -1, 0, -1);
    run(KLw,     "lw",     -1, 0, -1);
    run(KSw,     "sw",      4, 2, -1);
    run(KJal,    "jal",    -1, 0, -1);
    run(KJr,     "jr",     -1, 0, -1);
    run(KJ,      "j",      -1, 0, -1);
    run(KBeq,    "beq",    -1, 0, -1);
    run(KBltzal, "bltzal", -1, 0, -1);
    run(KBad,    "badop",  -1, 0, -1);
    run(KBadFn,  "badfn",  -1, 0, -1);
    run(KOri,    "ori_h",   2, 3, -1);
    run(KLw,     "lw_h",    5, 2, -1);
    run(KLw,     "lw_rst", -1, 0, 3);
    run(KAddu,   "addu2",  -1, 0, -1);

    @(negedge clk); #1;
    check_eq("drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
